// File: rtl/sequenciador_pilha_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pilha_pkg
//  Description : Shared opcodes, FSM state type and occupancy width helper
//                for the operand-stack sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pilha_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_DUP   = 3'd3;
    localparam logic [2:0] OP_SWAP  = 3'd4;
    localparam logic [2:0] OP_BINOP = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP1  = 3'd1,
        ST_POP2  = 3'd2,
        ST_CAP   = 3'd3,
        ST_EXEC  = 3'd4,
        ST_PUSH1 = 3'd5,
        ST_PUSH2 = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sequenciador_pilha_if.sv
`default_nettype none
// ============================================================================
//  Module      : sequenciador_pilha_if
//  Description : UC request/response, stack strobes and ULA operand bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sequenciador_pilha_if #(
    parameter int DEPTH = 16,
    parameter int DW    = 16,
    parameter int AW    = 32,
    parameter int CW    = pilha_pkg::cnt_w(DEPTH)
);
    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] imm;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] result;
    logic [CW-1:0] count;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_sel;
    logic [DW-1:0] stk_din_uc;
    logic [DW-1:0] stk_dout;
    logic [DW-1:0] stk_tos;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [AW-1:0] alu_res;

    modport slave (
        input  start, op, imm, stk_dout, stk_tos, alu_res,
        output busy, done, err, result, count,
               stk_push, stk_pop, stk_sel, stk_din_uc, alu_a, alu_b
    );

    modport master (
        output start, op, imm, stk_dout, stk_tos, alu_res,
        input  busy, done, err, result, count,
               stk_push, stk_pop, stk_sel, stk_din_uc, alu_a, alu_b
    );
endinterface
`default_nettype wire

// File: rtl/sequenciador_pilha_contador.sv
`default_nettype none
// ============================================================================
//  Module      : contador_pilha
//  Description : Stack occupancy counter with full / empty / two-or-more flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_pilha
    import pilha_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          push,
    input  wire logic          pop,
    output      logic [CW-1:0] count,
    output      logic          full,
    output      logic          empty,
    output      logic          ge2
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign ge2   = (count_q >= CW'(2));

endmodule
`default_nettype wire

// File: rtl/sequenciador_pilha.sv
`default_nettype none
// ============================================================================
//  Module      : sequenciador_pilha
//  Description : Multi-cycle sequencer issuing push/pop strobes and ULA
//                operands for one stack opcode at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequenciador_pilha
    import pilha_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    sequenciador_pilha_if.slave    bus
);

    localparam int CW = cnt_w(DEPTH);

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] y_q, y_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          push_q, push_d;
    logic          pop_q, pop_d;
    logic          sel_q, sel_d;

    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_ge2;
    logic          w_legal;

    contador_pilha #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_contador (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (pop_q),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty),
        .ge2   (w_ge2)
    );

    // BINOP at full is legal: it pops two before pushing one.
    always_comb begin
        w_legal = 1'b0;
        case (bus.op)
            OP_NOP:   w_legal = 1'b1;
            OP_PUSH:  w_legal = !w_full;
            OP_POP:   w_legal = !w_empty;
            OP_DUP:   w_legal = !w_empty && !w_full;
            OP_SWAP:  w_legal = w_ge2;
            OP_BINOP: w_legal = w_ge2;
            default:  w_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        din_d    = din_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    op_d = bus.op;
                    if (!w_legal) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        case (bus.op)
                            OP_PUSH: begin
                                state_d = ST_PUSH1;
                                din_d   = bus.imm;
                            end
                            OP_DUP: begin
                                state_d = ST_PUSH1;
                                din_d   = bus.stk_tos;
                            end
                            OP_POP, OP_SWAP, OP_BINOP: state_d = ST_POP1;
                            default:                   state_d = ST_DONE;
                        endcase
                    end
                end
            end
            ST_POP1: state_d = (op_q == OP_POP) ? ST_CAP : ST_POP2;
            ST_POP2: begin
                x_d     = bus.stk_dout;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                case (op_q)
                    OP_POP: begin
                        result_d = bus.stk_dout;
                        state_d  = ST_DONE;
                    end
                    OP_SWAP: begin
                        y_d     = bus.stk_dout;
                        din_d   = x_q;
                        state_d = ST_PUSH1;
                    end
                    default: begin
                        alu_a_d = bus.stk_dout;
                        alu_b_d = x_q;
                        state_d = ST_EXEC;
                    end
                endcase
            end
            // Operands stay held through PUSH1 so din_ULA is stable at the write.
            ST_EXEC: state_d = ST_PUSH1;
            ST_PUSH1: begin
                if (op_q == OP_SWAP) begin
                    din_d   = y_q;
                    state_d = ST_PUSH2;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_PUSH2: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
        done_d = (state_d == ST_DONE);
        push_d = (state_d == ST_PUSH1) || (state_d == ST_PUSH2);
        pop_d  = (state_d == ST_POP1) || (state_d == ST_POP2);
        sel_d  = (state_d == ST_PUSH1) && (op_d == OP_BINOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            din_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            din_q    <= din_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            push_q   <= push_d;
            pop_q    <= pop_d;
            sel_q    <= sel_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.result     = result_q;
    assign bus.count      = w_count;
    assign bus.stk_push   = push_q;
    assign bus.stk_pop    = pop_q;
    assign bus.stk_sel    = sel_q;
    assign bus.stk_din_uc = din_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_pilha.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequenciador_pilha
//  Description : Bench for sequenciador_pilha with a stack/ULA environment and
//                a queue-based model of the stack semantics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequenciador_pilha;
    import pilha_pkg::*;

    logic clk;
    logic rst;

    sequenciador_pilha_if #(.DEPTH(16), .DW(16), .AW(32)) bus ();

    sequenciador_pilha #(.DEPTH(16), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack (Pilha) and ULA environment
    logic [15:0] mem [0:15];
    logic [4:0]  sp;
    logic [4:0]  sp_m1;
    logic [15:0] dout_r;

    assign sp_m1        = sp - 5'd1;
    assign bus.stk_tos  = (sp != 5'd0) ? mem[sp_m1[3:0]] : 16'h0;
    assign bus.stk_dout = dout_r;
    assign bus.alu_res  = 32'(bus.alu_a) + 32'(bus.alu_b);

    always @(posedge clk) begin
        if (rst) begin
            sp     <= 5'd0;
            dout_r <= 16'h0;
        end else if (bus.stk_push && sp < 5'd16) begin
            mem[sp[3:0]] <= bus.stk_sel ? bus.alu_res[15:0] : bus.stk_din_uc;
            sp           <= sp + 5'd1;
        end else if (bus.stk_pop && sp != 5'd0) begin
            dout_r <= mem[sp_m1[3:0]];
            sp     <= sp_m1;
        end
    end

    // Reference model: the stack as a queue, back = top
    logic [15:0] mq[$];
    int nchk  = 0;
    int nfail = 0;

    function automatic bit legal(input logic [2:0] o, input int n);
        case (o)
            OP_NOP:           return 1'b1;
            OP_PUSH:          return n < 16;
            OP_POP:           return n >= 1;
            OP_DUP:           return (n >= 1) && (n < 16);
            OP_SWAP, OP_BINOP: return n >= 2;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        case (o)
            OP_PUSH, OP_DUP:   return 2;
            OP_POP:            return 3;
            OP_SWAP, OP_BINOP: return 6;
            default:           return 1;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Issue one opcode from a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [15:0] im, input bit hold,
                          output int lat, output bit got_err);
        int n, elat, epush, epop, pushes, pops, busy_bad, sel_bad, mism;
        bit e;
        logic [15:0] ea, eb, sa, sb, v, t;
        n = mq.size();
        e = !legal(o, n);
        elat = e ? 1 : lat_of(o);
        epush = 0; epop = 0; ea = 16'h0; eb = 16'h0;
        if (!e) begin
            case (o)
                OP_PUSH, OP_DUP: epush = 1;
                OP_POP:          epop = 1;
                OP_SWAP:  begin epush = 2; epop = 2; end
                OP_BINOP: begin epush = 1; epop = 2; ea = mq[n-2]; eb = mq[n-1]; end
                default: ;
            endcase
        end
        lat = 0; pushes = 0; pops = 0; busy_bad = 0; sel_bad = 0;
        sa = 16'h0; sb = 16'h0;
        bus.start = 1'b1; bus.op = o; bus.imm = im;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            if (bus.stk_push) begin
                pushes++;
                if (bus.stk_sel != (o == OP_BINOP)) sel_bad++;
            end
            if (bus.stk_pop) pops++;
            if (k == 4) begin sa = bus.alu_a; sb = bus.alu_b; end
            if (bus.done) begin
                lat = k;
                if (bus.busy) busy_bad++;
                break;
            end
            if (!bus.busy) busy_bad++;
        end
        got_err = bus.err;

        if (!e) begin
            case (o)
                OP_PUSH: mq.push_back(im);
                OP_DUP:  mq.push_back(mq[n-1]);
                OP_POP: begin
                    v = mq.pop_back();
                    check("pop_result", 32'(bus.result), 32'(v));
                end
                OP_SWAP: begin
                    v = mq.pop_back(); t = mq.pop_back();
                    mq.push_back(v); mq.push_back(t);
                end
                OP_BINOP: begin
                    void'(mq.pop_back()); void'(mq.pop_back());
                    mq.push_back(ea + eb);
                    check("alu_a", 32'(sa), 32'(ea));
                    check("alu_b", 32'(sb), 32'(eb));
                end
                default: ;
            endcase
        end

        check("done_latency", 32'(lat), 32'(elat));
        check("err", 32'(got_err), 32'(e));
        check("push_strobes", 32'(pushes), 32'(epush));
        check("pop_strobes", 32'(pops), 32'(epop));
        check("busy_window", 32'(busy_bad), 32'd0);
        check("sel_at_push", 32'(sel_bad), 32'd0);
        check("count", 32'(bus.count), 32'(mq.size()));
        check("stack_depth", 32'(sp), 32'(mq.size()));
        mism = 0;
        for (int i = 0; i < mq.size() && i < 16; i++)
            if (mem[i[3:0]] !== mq[i]) mism++;
        check("stack_contents", 32'(mism), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] imm;
        bit          exp_err;
        int          exp_lat;
        logic [15:0] exp_top;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int  lat;
        bit  er;
        int  seen;

        vecs = '{
            '{OP_PUSH,  16'd3, 1'b0, 2, 16'd3, 1},
            '{OP_PUSH,  16'd5, 1'b0, 2, 16'd5, 2},
            '{OP_BINOP, 16'd0, 1'b0, 6, 16'd8, 1},
            '{OP_PUSH,  16'd7, 1'b0, 2, 16'd7, 2},
            '{OP_PUSH,  16'd9, 1'b0, 2, 16'd9, 3},
            '{OP_SWAP,  16'd0, 1'b0, 6, 16'd7, 3},
            '{OP_NOP,   16'd0, 1'b0, 1, 16'd7, 3},
            '{3'd6,     16'd0, 1'b1, 1, 16'd7, 3},
            '{OP_DUP,   16'd0, 1'b0, 2, 16'd7, 4},
            '{OP_POP,   16'd0, 1'b0, 3, 16'd7, 3},
            '{OP_POP,   16'd0, 1'b0, 3, 16'd9, 2},
            '{OP_POP,   16'd0, 1'b0, 3, 16'd8, 1},
            '{OP_SWAP,  16'd0, 1'b1, 1, 16'd8, 1},
            '{OP_BINOP, 16'd0, 1'b1, 1, 16'd8, 1},
            '{OP_POP,   16'd0, 1'b0, 3, 16'd0, 0},
            '{OP_POP,   16'd0, 1'b1, 1, 16'd0, 0},
            '{OP_DUP,   16'd0, 1'b1, 1, 16'd0, 0},
            '{3'd7,     16'd0, 1'b1, 1, 16'd0, 0}
        };

        rst = 1'b1; bus.start = 1'b0; bus.op = 3'd0; bus.imm = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_push", 32'(bus.stk_push), 32'd0);
        check("rst_pop", 32'(bus.stk_pop), 32'd0);
        check("rst_sel", 32'(bus.stk_sel), 32'd0);
        check("rst_din_uc", 32'(bus.stk_din_uc), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].op, vecs[i].imm, 1'b0, lat, er);
            check("tab_latency", 32'(lat), 32'(vecs[i].exp_lat));
            check("tab_err", 32'(er), 32'(vecs[i].exp_err));
            check("tab_top", 32'(bus.stk_tos), 32'(vecs[i].exp_top));
            check("tab_count", 32'(bus.count), 32'(vecs[i].exp_cnt));
        end

        // Fill to capacity, then probe the full boundary.
        for (int i = 0; i < 16; i++)
            run_op(OP_PUSH, 16'($urandom), 1'b0, lat, er);
        check("full_count", 32'(bus.count), 32'd16);
        run_op(OP_PUSH, 16'h1234, 1'b0, lat, er);
        check("full_push_err", 32'(er), 32'd1);
        run_op(OP_DUP, 16'h0, 1'b0, lat, er);
        check("full_dup_err", 32'(er), 32'd1);
        run_op(OP_BINOP, 16'h0, 1'b0, lat, er);
        check("full_binop_ok", 32'(er), 32'd0);
        check("full_binop_count", 32'(bus.count), 32'd15);

        for (int i = 0; i < 60; i++)
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 1'b0, lat, er);

        // Reset during cycle 3 of a BINOP.
        run_op(OP_PUSH, 16'd11, 1'b0, lat, er);
        run_op(OP_PUSH, 16'd22, 1'b0, lat, er);
        bus.start = 1'b1; bus.op = OP_BINOP;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_count", 32'(bus.count), 32'd0);
        check("abort_strobes", {29'd0, bus.stk_push, bus.stk_pop, bus.stk_sel}, 32'd0);
        rst = 1'b0;
        mq.delete();
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // POP from [4] with start held through busy, then back-to-back in DONE.
        run_op(OP_PUSH, 16'd4, 1'b0, lat, er);
        run_op(OP_POP, 16'h0, 1'b1, lat, er);
        check("held_pop_result", 32'(bus.result), 32'd4);
        check("held_pop_latency", 32'(lat), 32'd3);
        run_op(OP_POP, 16'h0, 1'b0, lat, er);
        check("b2b_empty_pop_err", 32'(er), 32'd1);
        check("b2b_latency", 32'(lat), 32'd1);
        check("result_held", 32'(bus.result), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
